// File: rtl/tile_rom_fetch_arbiter.sv
// Round-robin arbiter that funnels per-layer tile-row fetches onto one
// toggle-handshake ROM port, with blank-tile bypass and an ack timeout.
module tile_rom_fetch_arbiter #(
    parameter int unsigned        NUM_CH     = 4,
    parameter int unsigned        CODE_W     = 16,
    parameter int unsigned        ROW_BITS   = 4,
    parameter int unsigned        WORD_SHIFT = 3,
    parameter int unsigned        ADDR_W     = 23,
    parameter int unsigned        DATA_W     = 64,
    parameter logic [CODE_W-1:0]  BLANK_MASK = CODE_W'(16'h7fff),
    parameter int unsigned        TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_req,
    output logic [NUM_CH-1:0]            ch_ack,
    input  logic [NUM_CH*CODE_W-1:0]     ch_code,
    input  logic [NUM_CH*ROW_BITS-1:0]   ch_row,
    input  logic [NUM_CH-1:0]            ch_yflip,
    output logic [NUM_CH-1:0]            ch_load,
    output logic [DATA_W-1:0]            load_data,
    output logic [ADDR_W-1:0]            rom_address,
    output logic                         rom_req,
    input  logic                         rom_ack,
    input  logic [DATA_W-1:0]            rom_data,
    output logic                         timeout_err
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]    cur, cur_nxt;
    logic [TMR_W-1:0]    timer, timer_nxt;
    logic [NUM_CH-1:0]   ch_ack_nxt, ch_load_nxt;
    logic [DATA_W-1:0]   load_data_nxt;
    logic [ADDR_W-1:0]   rom_address_nxt;
    logic                rom_req_nxt, timeout_err_nxt;

    logic [NUM_CH-1:0]   pending;
    logic                gnt_found;
    logic [IDX_W-1:0]    gnt_idx, cand;
    logic [CODE_W-1:0]   sel_code;
    logic [ROW_BITS-1:0] sel_row_eff;
    logic                sel_blank;
    logic [ADDR_W-1:0]   fetch_addr;
    logic                rom_done;

    // (base + step) mod NUM_CH without a divider
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned step);
        int unsigned s;
        s = 32'(base) + step;
        if (s >= NUM_CH) s = s - NUM_CH;
        return IDX_W'(s);
    endfunction

    // Round-robin pick of the first pending channel starting at rr_ptr
    always_comb begin
        pending   = ch_req ^ ch_ack;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = wrap_add(rr_ptr, k);
            if (!gnt_found && pending[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Granted channel's request fields and derived ROM address
    always_comb begin
        sel_code    = ch_code[32'(gnt_idx)*CODE_W +: CODE_W];
        sel_row_eff = ch_row[32'(gnt_idx)*ROW_BITS +: ROW_BITS]
                      ^ {ROW_BITS{ch_yflip[gnt_idx]}};
        sel_blank   = ((sel_code & BLANK_MASK) == '0);
        fetch_addr  = ADDR_W'({sel_code, sel_row_eff, {WORD_SHIFT{1'b0}}});
        rom_done    = (rom_req == rom_ack);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt       = state;
        rr_ptr_nxt      = rr_ptr;
        cur_nxt         = cur;
        timer_nxt       = timer;
        ch_ack_nxt      = ch_ack;
        ch_load_nxt     = '0;
        load_data_nxt   = load_data;
        rom_address_nxt = rom_address;
        rom_req_nxt     = rom_req;
        timeout_err_nxt = timeout_err;

        case (state)
            ST_IDLE: begin
                if (gnt_found) begin
                    if (sel_blank) begin
                        ch_ack_nxt[gnt_idx]  = ~ch_ack[gnt_idx];
                        ch_load_nxt[gnt_idx] = 1'b1;
                        load_data_nxt        = '0;
                        rr_ptr_nxt           = wrap_add(gnt_idx, 1);
                    end else begin
                        rom_address_nxt = fetch_addr;
                        rom_req_nxt     = ~rom_req;
                        timer_nxt       = '0;
                        cur_nxt         = gnt_idx;
                        state_nxt       = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (rom_done) begin
                    load_data_nxt    = rom_data;
                    ch_load_nxt[cur] = 1'b1;
                    ch_ack_nxt[cur]  = ~ch_ack[cur];
                    rr_ptr_nxt       = wrap_add(cur, 1);
                    state_nxt        = ST_IDLE;
                end else if ((TIMEOUT != 0) && (timer == TMR_W'(TIMEOUT - 1))) begin
                    // Give the layer blank data now; the late ROM reply is dropped in DRAIN
                    load_data_nxt    = '0;
                    ch_load_nxt[cur] = 1'b1;
                    ch_ack_nxt[cur]  = ~ch_ack[cur];
                    rr_ptr_nxt       = wrap_add(cur, 1);
                    timeout_err_nxt  = 1'b1;
                    state_nxt        = ST_DRAIN;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (rom_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            cur         <= '0;
            timer       <= '0;
            ch_ack      <= '0;
            ch_load     <= '0;
            load_data   <= '0;
            rom_address <= '0;
            rom_req     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            cur         <= cur_nxt;
            timer       <= timer_nxt;
            ch_ack      <= ch_ack_nxt;
            ch_load     <= ch_load_nxt;
            load_data   <= load_data_nxt;
            rom_address <= rom_address_nxt;
            rom_req     <= rom_req_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

endmodule

// File: tb/tb_tile_rom_fetch_arbiter.sv
// Directed + randomized bench for tile_rom_fetch_arbiter with a toggle-handshake ROM model.
module tb_tile_rom_fetch_arbiter;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CODE_W  = 16;
    localparam int unsigned ROW_B   = 4;
    localparam int unsigned ADDR_W  = 23;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned TIMEOUT = 8;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_CH-1:0]          ch_req;
    logic [NUM_CH-1:0]          ch_ack;
    logic [NUM_CH*CODE_W-1:0]   ch_code;
    logic [NUM_CH*ROW_B-1:0]    ch_row;
    logic [NUM_CH-1:0]          ch_yflip;
    logic [NUM_CH-1:0]          ch_load;
    logic [DATA_W-1:0]          load_data;
    logic [ADDR_W-1:0]          rom_address;
    logic                       rom_req;
    logic                       rom_ack;
    logic [DATA_W-1:0]          rom_data;
    logic                       timeout_err;

    tile_rom_fetch_arbiter #(
        .NUM_CH(NUM_CH), .CODE_W(CODE_W), .ROW_BITS(ROW_B), .WORD_SHIFT(3),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLANK_MASK(16'h7fff), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .ch_req(ch_req), .ch_ack(ch_ack), .ch_code(ch_code), .ch_row(ch_row),
        .ch_yflip(ch_yflip), .ch_load(ch_load), .load_data(load_data),
        .rom_address(rom_address), .rom_req(rom_req), .rom_ack(rom_ack),
        .rom_data(rom_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ROM model: answers each toggle after rom_delay cycles unless rom_never is set
    int          rom_cnt;
    int          rom_delay    = 2;
    bit          rom_never    = 1'b0;
    bit          rom_fixed_en = 1'b0;
    logic [63:0] rom_fixed    = '0;

    function automatic logic [63:0] rom_fn(input logic [ADDR_W-1:0] a);
        return {a, 41'(~a)} ^ 64'h0123_4567_89ab_cdef;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            rom_ack  <= 1'b0;
            rom_cnt  <= 0;
            rom_data <= '0;
        end else if (rom_req !== rom_ack) begin
            if (!rom_never && (rom_cnt + 1 >= rom_delay)) begin
                rom_ack  <= rom_req;
                rom_data <= rom_fixed_en ? rom_fixed : rom_fn(rom_address);
                rom_cnt  <= 0;
            end else begin
                rom_cnt <= rom_cnt + 1;
            end
        end
    end

    // Reference: byte address of a tile row and the data a layer should receive
    function automatic logic [ADDR_W-1:0] exp_addr(input logic [15:0] code, input logic [3:0] row,
                                                   input logic yf);
        logic [3:0] r;
        r = yf ? (4'hF - row) : row;
        return ADDR_W'(code) * 128 + ADDR_W'(r) * 8;
    endfunction

    function automatic logic [63:0] exp_data(input logic [15:0] code, input logic [3:0] row,
                                             input logic yf);
        if (code % 16'h8000 == 16'h0) return 64'h0;
        return rom_fixed_en ? rom_fixed : rom_fn(exp_addr(code, row, yf));
    endfunction

    logic [63:0]       exp_q [NUM_CH][$];
    int                order_q[$];
    logic [NUM_CH-1:0] prev_ack;
    bit                prev_rst = 1'b1;

    // Load monitor: each strobe must match the oldest outstanding request of that channel
    always @(negedge clk) begin
        if (!reset && !prev_rst) begin
            check("ack_follows_load", 64'(ch_ack ^ prev_ack), 64'(ch_load));
            if (ch_load != '0) check("load_onehot", 64'($countones(ch_load)), 64'd1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_load[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("unexpected_load_ch%0d", i), 64'(ch_load[i]), 64'd0);
                    end else begin
                        check($sformatf("load_data_ch%0d", i), load_data, exp_q[i].pop_front());
                        order_q.push_back(i);
                    end
                end
            end
        end
        prev_ack <= ch_ack;
        prev_rst <= reset;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic request(input int ch, input logic [15:0] code, input logic [3:0] row,
                           input logic yf, input bit times_out);
        ch_code[ch*CODE_W +: CODE_W] = code;
        ch_row[ch*ROW_B +: ROW_B]    = row;
        ch_yflip[ch]                 = yf;
        exp_q[ch].push_back(times_out ? 64'h0 : exp_data(code, row, yf));
        ch_req[ch] = ~ch_req[ch];
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((ch_req !== ch_ack) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 64'(ch_ack), 64'(ch_req));
        tick(1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ch_ack"},      64'(ch_ack),      64'h0);
        check({tag, "_ch_load"},     64'(ch_load),     64'h0);
        check({tag, "_load_data"},   load_data,        64'h0);
        check({tag, "_rom_address"}, 64'(rom_address), 64'h0);
        check({tag, "_rom_req"},     64'(rom_req),     64'h0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp_order[$];
        logic        r1;
        logic [15:0] code;

        reset = 1'b1; ch_req = '0; ch_code = '0; ch_row = '0; ch_yflip = '0;
        tick(3);
        @(negedge clk);
        check_reset_values("reset");
        tick(1);
        reset = 1'b0;
        tick(2);

        // Single fetch with a fixed ROM word
        rom_fixed_en = 1'b1; rom_fixed = 64'hA5A5_A5A5_A5A5_A5A5; rom_delay = 4;
        request(0, 16'h0123, 4'h5, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        check("single_addr",     64'(rom_address), 64'h0091A8);
        check("single_rom_req",  64'(rom_req), 64'h1);
        wait_idle("single", 50);

        // Y-flip selects the mirrored row
        request(0, 16'h0123, 4'h5, 1'b1, 1'b0);
        @(posedge clk); @(negedge clk);
        check("yflip_addr", 64'(rom_address), 64'(exp_addr(16'h0123, 4'h5, 1'b1)));
        wait_idle("yflip", 50);

        // Blank tile: bypass the ROM, strobe zero data the cycle after the toggle
        rom_fixed_en = 1'b0;
        r1 = rom_req;
        request(2, 16'h8000, 4'h3, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        check("blank_load",    64'(ch_load), 64'h4);
        check("blank_data",    load_data,    64'h0);
        check("blank_rom_req", 64'(rom_req), 64'(r1));
        wait_idle("blank", 20);

        // Move the round-robin pointer back to channel 0
        request(3, 16'h0042, 4'h1, 1'b0, 1'b0);
        wait_idle("rr_prep", 50);

        // Round-robin: all four pending, then 0,1,3
        rom_delay = 2;
        order_q.delete();
        for (int c = 0; c < NUM_CH; c++)
            request(c, 16'(16'h0100 + c), 4'(c), 1'b0, 1'b0);
        wait_idle("rr_all", 200);
        exp_order = '{0, 1, 2, 3};
        check("rr_all_count", 64'(order_q.size()), 64'(exp_order.size()));
        for (int k = 0; k < exp_order.size(); k++)
            if (k < order_q.size()) check($sformatf("rr_all_order%0d", k), 64'(order_q[k]), 64'(exp_order[k]));
        order_q.delete();
        request(1, 16'h0211, 4'h2, 1'b1, 1'b0);
        request(3, 16'h0233, 4'h4, 1'b0, 1'b0);
        request(0, 16'h0200, 4'h6, 1'b0, 1'b0);
        wait_idle("rr_sub", 200);
        exp_order = '{0, 1, 3};
        check("rr_sub_count", 64'(order_q.size()), 64'(exp_order.size()));
        for (int k = 0; k < exp_order.size(); k++)
            if (k < order_q.size()) check($sformatf("rr_sub_order%0d", k), 64'(order_q[k]), 64'(exp_order[k]));

        // Timeout: no ack for TIMEOUT cycles, then a held-off second request
        rom_never = 1'b1;
        request(1, 16'h0456, 4'h2, 1'b0, 1'b1);
        @(posedge clk); @(negedge clk);
        r1 = rom_req;
        repeat (TIMEOUT - 1) @(posedge clk);
        @(negedge clk);
        check("timeout_early_load", 64'(ch_load), 64'h0);
        @(posedge clk); @(negedge clk);
        check("timeout_load", 64'(ch_load),     64'h2);
        check("timeout_data", load_data,        64'h0);
        check("timeout_err",  64'(timeout_err), 64'h1);
        tick(1);
        request(2, 16'h0777, 4'h1, 1'b0, 1'b0);
        tick(6);
        @(negedge clk);
        check("drain_no_issue", 64'(rom_req), 64'(r1));
        tick(1);
        rom_never = 1'b0;
        wait_idle("drain", 100);
        check("drain_next_addr",  64'(rom_address), 64'(exp_addr(16'h0777, 4'h1, 1'b0)));
        check("timeout_err_held", 64'(timeout_err), 64'h1);

        // Reset two cycles into a fetch abandons it
        rom_delay = 10;
        request(0, 16'h0321, 4'h7, 1'b0, 1'b0);
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        ch_req = '0;
        for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("mid_reset");
        tick(1);
        reset = 1'b0;
        rom_delay = 3;
        tick(2);
        request(0, 16'h0321, 4'h7, 1'b1, 1'b0);
        wait_idle("post_reset", 50);
        check("post_reset_addr", 64'(rom_address), 64'(exp_addr(16'h0321, 4'h7, 1'b1)));

        // Randomized traffic: every request must see exactly one matching load
        for (int cyc = 0; cyc < 600; cyc++) begin
            rom_delay = int'($urandom_range(1, 5));
            for (int c = 0; c < NUM_CH; c++) begin
                if ((ch_req[c] == ch_ack[c]) && ($urandom_range(0, 3) == 0)) begin
                    code = 16'($urandom);
                    if ($urandom_range(0, 3) == 0) code = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000;
                    request(c, code, 4'($urandom), 1'($urandom), 1'b0);
                end
            end
            tick(1);
        end
        wait_idle("random", 2000);
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("random_drained_ch%0d", c), 64'(exp_q[c].size()), 64'h0);
        check("random_no_timeout", 64'(timeout_err), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
